// File: rtl/nfc_ecc_fix_ctrl_pkg.sv
// Shared types and default sizing for the ECC fix sequencer.
// The states cover the encode drain, the decode read-modify-write loop and the done handshake.
package nfc_ecc_fix_ctrl_pkg;

    localparam int NFC_DAT_WID    = 16;
    localparam int NFC_ECC_AWID   = 12;
    localparam int NFC_PAR_BYTES  = 14;
    localparam int NFC_ERR_MAX    = 8;
    localparam int NFC_PAGE_BYTES = 512;

    localparam logic [1:0] MODE_X16 = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENC_POP,
        ST_ENC_WR,
        ST_DEC_POP,
        ST_DEC_RREQ,
        ST_DEC_RWAIT,
        ST_DEC_WREQ,
        ST_DONE
    } fix_st_t;

endpackage

// File: rtl/nfc_ecc_loc_map.sv
// Maps an ECC error location to a page-buffer address, a bit index within the bus word and an in-page flag.
// Purely combinational, so it adds no latency and has no flow control of its own.
module nfc_ecc_loc_map
    import nfc_ecc_fix_ctrl_pkg::*;
#(
    parameter int ECC_AWID   = NFC_ECC_AWID,
    parameter int PAGE_BYTES = NFC_PAGE_BYTES
) (
    input  logic [ECC_AWID-1:0] loc,
    input  logic                wide,
    output logic [ECC_AWID-4:0] waddr,
    output logic [3:0]          bit_idx,
    output logic                in_rng
);

    logic [ECC_AWID-4:0] baddr;

    assign baddr   = loc[ECC_AWID-1:3];
    assign waddr   = wide ? (baddr >> 1) : baddr;
    // On a 16-bit bus an odd byte address lands in the upper half of the word.
    assign bit_idx = wide ? {baddr[0], loc[2:0]} : {1'b0, loc[2:0]};
    assign in_rng  = (32'(baddr) < 32'(PAGE_BYTES));

endmodule

// File: rtl/nfc_ecc_fix_ctrl.sv
// Drains ECC parity into the spare area on encode, or flips reported error bits by read-modify-write on decode.
// Encode: 2 cycles per item; decode: 4 per in-page error, 1 per skip; buf_* held stable until buf_gnt.
module nfc_ecc_fix_ctrl
    import nfc_ecc_fix_ctrl_pkg::*;
#(
    parameter int DAT_WID    = NFC_DAT_WID,
    parameter int ECC_AWID   = NFC_ECC_AWID,
    parameter int PAR_BYTES  = NFC_PAR_BYTES,
    parameter int ERR_MAX    = NFC_ERR_MAX,
    parameter int PAGE_BYTES = NFC_PAGE_BYTES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                nfc_dat_dir,
    input  logic [1:0]          nfc_mode,
    input  logic [ECC_AWID-4:0] spare_base,
    input  logic                ecc_enc_rdy,
    input  logic                ecc_dec_rdy,
    input  logic [3:0]          ecc_err_cnt,
    input  logic                ecc_dec_fail,
    output logic                mem_if_rd,
    input  logic [DAT_WID-1:0]  mem_enc_dat,
    input  logic [ECC_AWID-1:0] mem_dec_addr,
    output logic                buf_req,
    output logic                buf_we,
    output logic [ECC_AWID-4:0] buf_addr,
    output logic [DAT_WID-1:0]  buf_wdat,
    input  logic                buf_gnt,
    input  logic [DAT_WID-1:0]  buf_rdat,
    output logic                cor_busy,
    output logic                cor_done,
    output logic                cor_fail,
    output logic                cor_ovr,
    output logic [3:0]          cor_fix_cnt
);

    localparam int BA_W = ECC_AWID - 3;

    fix_st_t            state;
    logic               wide_q;
    logic [7:0]         remain;
    logic [BA_W-1:0]    idx;
    logic [DAT_WID-1:0] wdat_q;
    logic [DAT_WID-1:0] rdat_q;
    logic [BA_W-1:0]    waddr_q;
    logic [3:0]         bit_q;

    logic               wide_in;
    logic               cnt_over;
    logic [BA_W-1:0]    enc_addr;
    logic [DAT_WID-1:0] flip_mask;
    logic [BA_W-1:0]    map_waddr;
    logic [3:0]         map_bit;
    logic               map_in_rng;

    assign wide_in   = (nfc_mode == MODE_X16);
    assign cnt_over  = (32'(ecc_err_cnt) > 32'(ERR_MAX));
    assign enc_addr  = wide_q ? ((spare_base >> 1) + idx) : (spare_base + idx);
    assign flip_mask = {{(DAT_WID-1){1'b0}}, 1'b1} << bit_q;

    nfc_ecc_loc_map #(
        .ECC_AWID   (ECC_AWID),
        .PAGE_BYTES (PAGE_BYTES)
    ) u_loc_map (
        .loc     (mem_dec_addr),
        .wide    (wide_q),
        .waddr   (map_waddr),
        .bit_idx (map_bit),
        .in_rng  (map_in_rng)
    );

    always_comb begin
        mem_if_rd = 1'b0;
        buf_req   = 1'b0;
        buf_we    = 1'b0;
        buf_addr  = '0;
        buf_wdat  = '0;
        case (state)
            ST_ENC_POP, ST_DEC_POP: mem_if_rd = 1'b1;
            ST_ENC_WR: begin
                buf_req  = 1'b1;
                buf_we   = 1'b1;
                buf_addr = enc_addr;
                buf_wdat = wdat_q;
            end
            ST_DEC_RREQ: begin
                buf_req  = 1'b1;
                buf_addr = waddr_q;
            end
            ST_DEC_WREQ: begin
                buf_req  = 1'b1;
                buf_we   = 1'b1;
                buf_addr = waddr_q;
                buf_wdat = rdat_q ^ flip_mask;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wide_q      <= 1'b0;
            remain      <= '0;
            idx         <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            waddr_q     <= '0;
            bit_q       <= '0;
            cor_busy    <= 1'b0;
            cor_done    <= 1'b0;
            cor_fail    <= 1'b0;
            cor_ovr     <= 1'b0;
            cor_fix_cnt <= '0;
        end else begin
            cor_done <= 1'b0;
            cor_fail <= 1'b0;
            cor_ovr  <= (state != ST_IDLE) && (ecc_enc_rdy || ecc_dec_rdy);
            case (state)
                ST_IDLE: begin
                    if (ecc_enc_rdy && nfc_dat_dir) begin
                        wide_q   <= wide_in;
                        remain   <= wide_in ? 8'(PAR_BYTES / 2) : 8'(PAR_BYTES);
                        idx      <= '0;
                        cor_busy <= 1'b1;
                        state    <= ST_ENC_POP;
                    end else if (ecc_dec_rdy && !nfc_dat_dir) begin
                        wide_q      <= wide_in;
                        remain      <= {4'b0, ecc_err_cnt};
                        cor_fix_cnt <= '0;
                        if (ecc_dec_fail || (ecc_err_cnt == 4'd0) || cnt_over) begin
                            cor_done <= 1'b1;
                            cor_fail <= ecc_dec_fail || cnt_over;
                            state    <= ST_DONE;
                        end else begin
                            cor_busy <= 1'b1;
                            state    <= ST_DEC_POP;
                        end
                    end
                end
                ST_ENC_POP: begin
                    wdat_q <= wide_q ? mem_enc_dat : {{(DAT_WID-8){1'b0}}, mem_enc_dat[7:0]};
                    state  <= ST_ENC_WR;
                end
                ST_ENC_WR: begin
                    if (buf_gnt) begin
                        remain <= remain - 8'd1;
                        idx    <= idx + 1'b1;
                        if (remain == 8'd1) begin
                            cor_busy <= 1'b0;
                            cor_done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_ENC_POP;
                        end
                    end
                end
                ST_DEC_POP: begin
                    if (map_in_rng) begin
                        waddr_q <= map_waddr;
                        bit_q   <= map_bit;
                        state   <= ST_DEC_RREQ;
                    end else begin
                        // Parity-region error: drop it and pop the next one (stay in POP).
                        remain <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            cor_busy <= 1'b0;
                            cor_done <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DEC_RREQ: begin
                    if (buf_gnt) state <= ST_DEC_RWAIT;
                end
                ST_DEC_RWAIT: begin
                    rdat_q <= buf_rdat;
                    state  <= ST_DEC_WREQ;
                end
                ST_DEC_WREQ: begin
                    if (buf_gnt) begin
                        cor_fix_cnt <= cor_fix_cnt + 4'd1;
                        remain      <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            cor_busy <= 1'b0;
                            cor_done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_DEC_POP;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end

endmodule
